// File: rtl/serial_adder64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_adder64 (with FullAdder cell)                            |
// | Purpose  : Bit-serial WIDTH-bit adder, LSB first, one FullAdder per clock. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);
  assign Sum      = A ^ B ^ CarryIn;
  assign CarryOut = (A & B) | (CarryIn & (A ^ B));
endmodule

module serial_adder64 #(
  parameter int WIDTH = 64
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CarryIn,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int c_countWidth = $clog2(WIDTH) + 1;
  localparam logic [c_countWidth-1:0] c_lastBit = c_countWidth'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [WIDTH-1:0]        r_opX;
  logic [WIDTH-1:0]        r_opY;
  logic [WIDTH-1:0]        r_result;
  logic                    r_carry;
  logic [c_countWidth-1:0] r_count;

  logic             w_sum;
  logic             w_carryOut;
  logic [WIDTH-1:0] w_resultNext;

  FullAdder u_fullAdder (
    .A        (r_opX[0]),
    .B        (r_opY[0]),
    .CarryIn  (r_carry),
    .Sum      (w_sum),
    .CarryOut (w_carryOut)
  );

  generate
    if (WIDTH == 1) begin : g_singleBit
      assign w_resultNext = w_sum;
    end else begin : g_multiBit
      assign w_resultNext = {w_sum, r_result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= S_IDLE;
      r_opX    <= '0;
      r_opY    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      Ready    <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_opX   <= X;
            r_opY   <= Y;
            r_carry <= CarryIn;
            r_count <= '0;
            r_state <= S_RUN;
            Ready   <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_result <= w_resultNext;
          r_carry  <= w_carryOut;
          r_opX    <= r_opX >> 1;
          r_opY    <= r_opY >> 1;
          r_count  <= r_count + c_countWidth'(1);
          if (r_count == c_lastBit) begin
            // The carry flop during the last bit is exactly the carry into the MSB.
            Sum      <= w_resultNext;
            CarryOut <= w_carryOut;
            Overflow <= r_carry ^ w_carryOut;
            r_state  <= S_DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          Done    <= 1'b0;
          Ready   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          Ready   <= 1'b1;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
